id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_if.sv | 61 ++++++
 rtl/id_ex_reg.sv | 105 ++++++++++
 tb/tb_id_ex_reg.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline-register bus: decode-stage inputs, writeback port, hazard controls and EX-stage outputs.
interface id_ex_reg_if;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned OPW   = 4;
  localparam int unsigned CNTW  = 16;

  logic            stall;
  logic            flush;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RW-1:0]   id_rs1;
  logic [RW-1:0]   id_rs2;
  logic [RW-1:0]   id_rd;
  logic [OPW-1:0]  id_alu_op;
  logic            id_alu_src;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_reg_write;
  logic            id_mem_to_reg;
  logic            wb_reg_write;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [RW-1:0]   ex_rs1;
  logic [RW-1:0]   ex_rs2;
  logic [RW-1:0]   ex_rd;
  logic [OPW-1:0]  ex_alu_op;
  logic            ex_alu_src;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_mem_to_reg;
  logic [CNTW-1:0] bubble_cnt;

  modport master (
    output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_op, id_alu_src, id_mem_read,
           id_mem_write, id_reg_write, id_mem_to_reg, wb_reg_write, wb_rd, wb_data,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_mem_to_reg, bubble_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_op, id_alu_src, id_mem_read,
           id_mem_write, id_reg_write, id_mem_to_reg, wb_reg_write, wb_rd, wb_data,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_mem_to_reg, bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/stall, writeback bypass on load, operand refresh while
// stalled, and a saturating count of bubbles entering EX.
module id_ex_reg (
  input logic        clk,
  input logic        reset,
  id_ex_reg_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 4;
  localparam int unsigned CNTW = 16;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [OPW-1:0]  alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
  } ex_t;

  ex_t             r_ex;
  ex_t             w_load;
  logic [CNTW-1:0] r_bubble_cnt;
  logic            w_wb_live;
  logic            w_byp_rs1;
  logic            w_byp_rs2;
  logic            w_ref_rs1;
  logic            w_ref_rs2;
  logic            w_bubble_in;

  // x0 is hardwired, so a writeback to it never forwards.
  assign w_wb_live = bus.wb_reg_write && (bus.wb_rd != RW'(0));
  assign w_byp_rs1 = w_wb_live && (bus.wb_rd == bus.id_rs1);
  assign w_byp_rs2 = w_wb_live && (bus.wb_rd == bus.id_rs2);
  assign w_ref_rs1 = r_ex.valid && w_wb_live && (bus.wb_rd == r_ex.rs1);
  assign w_ref_rs2 = r_ex.valid && w_wb_live && (bus.wb_rd == r_ex.rs2);

  assign w_bubble_in = bus.flush || (!bus.stall && !bus.id_valid);

  // Next EX contents on a plain load; side-effecting controls gated by id_valid.
  always_comb begin
    w_load            = '0;
    w_load.valid      = bus.id_valid;
    w_load.pc         = bus.id_pc;
    w_load.rs1_data   = w_byp_rs1 ? bus.wb_data : bus.id_rs1_data;
    w_load.rs2_data   = w_byp_rs2 ? bus.wb_data : bus.id_rs2_data;
    w_load.imm        = bus.id_imm;
    w_load.rs1        = bus.id_rs1;
    w_load.rs2        = bus.id_rs2;
    w_load.rd         = bus.id_rd;
    w_load.alu_op     = bus.id_alu_op;
    w_load.alu_src    = bus.id_alu_src;
    w_load.mem_read   = bus.id_valid && bus.id_mem_read;
    w_load.mem_write  = bus.id_valid && bus.id_mem_write;
    w_load.reg_write  = bus.id_valid && bus.id_reg_write;
    w_load.mem_to_reg = bus.id_mem_to_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex <= '0;
    end else if (bus.flush) begin
      r_ex <= '0;
    end else if (bus.stall) begin
      if (w_ref_rs1) r_ex.rs1_data <= bus.wb_data;
      if (w_ref_rs2) r_ex.rs2_data <= bus.wb_data;
    end else begin
      r_ex <= w_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble_in && (r_bubble_cnt != CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + CNTW'(1);
    end
  end

  assign bus.ex_valid      = r_ex.valid;
  assign bus.ex_pc         = r_ex.pc;
  assign bus.ex_rs1_data   = r_ex.rs1_data;
  assign bus.ex_rs2_data   = r_ex.rs2_data;
  assign bus.ex_imm        = r_ex.imm;
  assign bus.ex_rs1        = r_ex.rs1;
  assign bus.ex_rs2        = r_ex.rs2;
  assign bus.ex_rd         = r_ex.rd;
  assign bus.ex_alu_op     = r_ex.alu_op;
  assign bus.ex_alu_src    = r_ex.alu_src;
  assign bus.ex_mem_read   = r_ex.mem_read;
  assign bus.ex_mem_write  = r_ex.mem_write;
  assign bus.ex_reg_write  = r_ex.reg_write;
  assign bus.ex_mem_to_reg = r_ex.mem_to_reg;
  assign bus.bubble_cnt    = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: a per-edge reference model checked every cycle plus literal spot checks.
module tb_id_ex_reg;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  id_ex_reg_if bus ();

  id_ex_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
  } ex_t;

  ex_t  m_ex;
  int   m_bub;
  logic chk_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: each edge, apply the highest-priority rule that holds.
  always @(posedge clk) begin
    ex_t  dut_ex;
    logic [15:0] exp_cnt;
    if (reset) begin
      m_ex  = '0;
      m_bub = 0;
    end else if (bus.flush) begin
      m_ex  = '0;
      m_bub = m_bub + 1;
    end else if (bus.stall) begin
      if (m_ex.valid && bus.wb_reg_write && bus.wb_rd != 5'd0) begin
        if (bus.wb_rd == m_ex.rs1) m_ex.rs1_data = bus.wb_data;
        if (bus.wb_rd == m_ex.rs2) m_ex.rs2_data = bus.wb_data;
      end
    end else begin
      m_ex = '{bus.id_valid, bus.id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm,
               bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_alu_op, bus.id_alu_src,
               bus.id_mem_read, bus.id_mem_write, bus.id_reg_write, bus.id_mem_to_reg};
      if (bus.wb_reg_write && bus.wb_rd != 5'd0) begin
        if (bus.wb_rd == bus.id_rs1) m_ex.rs1_data = bus.wb_data;
        if (bus.wb_rd == bus.id_rs2) m_ex.rs2_data = bus.wb_data;
      end
      if (!bus.id_valid) begin
        m_ex.mem_read  = 1'b0;
        m_ex.mem_write = 1'b0;
        m_ex.reg_write = 1'b0;
        m_bub = m_bub + 1;
      end
    end
    #1;
    if (chk_en) begin
      exp_cnt = (m_bub > 65535) ? 16'hFFFF : 16'(m_bub);
      dut_ex = '{bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
                 bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_alu_op, bus.ex_alu_src,
                 bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_mem_to_reg};
      n_chk++;
      if (dut_ex !== m_ex) begin
        n_err++;
        $display("FAIL model_ex @%0t: got %h expected %h", $time, dut_ex, m_ex);
      end
      n_chk++;
      if (bus.bubble_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL model_bubble_cnt @%0t: got %h expected %h", $time, bus.bubble_cnt, exp_cnt);
      end
    end
  end

  task automatic idle();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_pc = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0; bus.id_alu_op = 0;
    bus.id_alu_src = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.id_reg_write = 0; bus.id_mem_to_reg = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_chk = 0; n_err = 0; chk_en = 0;
    m_ex = '0; m_bub = 0;
    idle();
    reset = 1;
    @(posedge clk); chk_en = 1; #2;
    step();
    reset = 0;
    chk("reset_valid", 32'(bus.ex_valid), 32'h0);
    chk("reset_pc", bus.ex_pc, 32'h0);
    chk("reset_cnt", 32'(bus.bubble_cnt), 32'h0);

    // Basic load
    bus.id_valid = 1; bus.id_rs2_data = 32'h0000_1234; bus.id_rd = 5; bus.id_reg_write = 1;
    bus.id_imm = 32'hFFFF_FFF0; bus.id_alu_op = 4'hA; bus.id_alu_src = 1;
    step();
    chk("load_rs2_data", bus.ex_rs2_data, 32'h0000_1234);
    chk("load_rd", 32'(bus.ex_rd), 32'd5);
    chk("load_reg_write", 32'(bus.ex_reg_write), 32'd1);
    chk("load_valid", 32'(bus.ex_valid), 32'd1);
    chk("load_imm", bus.ex_imm, 32'hFFFF_FFF0);

    // Writeback bypass on load
    idle();
    bus.id_valid = 1; bus.id_rs1 = 7; bus.id_rs1_data = 32'h1;
    bus.wb_reg_write = 1; bus.wb_rd = 7; bus.wb_data = 32'hDEAD_BEEF;
    step();
    chk("bypass_rs1", bus.ex_rs1_data, 32'hDEAD_BEEF);
    bus.wb_rd = 0; bus.id_rs1 = 0;
    step();
    chk("bypass_x0", bus.ex_rs1_data, 32'h1);
    bus.id_rs1 = 7; bus.id_rs2 = 4; bus.id_rs2_data = 32'h2;
    bus.wb_rd = 4; bus.wb_data = 32'h0000_CAFE;
    step();
    chk("bypass_rs2_only_rs2", bus.ex_rs2_data, 32'h0000_CAFE);
    chk("bypass_rs2_only_rs1", bus.ex_rs1_data, 32'h1);
    bus.wb_reg_write = 0;
    step();
    chk("no_bypass_wb_off", bus.ex_rs2_data, 32'h2);

    // Stall hold then refresh from writeback
    idle();
    bus.id_valid = 1; bus.id_rs2 = 3; bus.id_rs2_data = 32'h10; bus.id_pc = 32'h100;
    step();
    bus.stall = 1; bus.id_rs2_data = 32'h99; bus.id_pc = 32'h999; bus.id_valid = 0;
    step();
    chk("stall_c1_rs2", bus.ex_rs2_data, 32'h10);
    bus.wb_reg_write = 1; bus.wb_rd = 3; bus.wb_data = 32'h55;
    step();
    chk("stall_c2_rs2", bus.ex_rs2_data, 32'h55);
    bus.wb_reg_write = 0;
    step();
    chk("stall_c3_rs2", bus.ex_rs2_data, 32'h55);
    chk("stall_pc", bus.ex_pc, 32'h100);
    chk("stall_valid", 32'(bus.ex_valid), 32'd1);
    chk("stall_cnt", 32'(bus.bubble_cnt), 32'd0);

    // Load of an invalid slot suppresses side effects and counts a bubble
    idle();
    bus.id_mem_read = 1; bus.id_mem_write = 1; bus.id_reg_write = 1; bus.id_pc = 32'h200;
    step();
    chk("inv_mem_write", 32'(bus.ex_mem_write), 32'd0);
    chk("inv_reg_write", 32'(bus.ex_reg_write), 32'd0);
    chk("inv_pc", bus.ex_pc, 32'h200);
    chk("inv_cnt", 32'(bus.bubble_cnt), 32'd1);

    // Flush wins over stall
    idle();
    bus.id_valid = 1; bus.id_mem_write = 1; bus.id_rd = 9;
    step();
    chk("store_mem_write", 32'(bus.ex_mem_write), 32'd1);
    bus.stall = 1; bus.flush = 1;
    step();
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_mem_write", 32'(bus.ex_mem_write), 32'd0);
    chk("flush_rd", 32'(bus.ex_rd), 32'd0);
    chk("flush_cnt", 32'(bus.bubble_cnt), 32'd2);

    // Reset mid-stall discards contents; next edge loads normally
    idle();
    bus.id_valid = 1; bus.id_pc = 32'h300;
    step();
    bus.stall = 1; reset = 1;
    step();
    chk("rst_stall_pc", bus.ex_pc, 32'h0);
    chk("rst_stall_cnt", 32'(bus.bubble_cnt), 32'd0);
    reset = 0; bus.stall = 0; bus.id_pc = 32'h400;
    step();
    chk("post_rst_pc", bus.ex_pc, 32'h400);

    // Reset priority over everything
    reset = 1; bus.flush = 1; bus.stall = 1; bus.id_valid = 1;
    bus.wb_reg_write = 1; bus.wb_rd = 1; bus.wb_data = 32'h7;
    step();
    chk("rst_prio_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_prio_pc", bus.ex_pc, 32'h0);
    chk("rst_prio_cnt", 32'(bus.bubble_cnt), 32'd0);

    // Saturation
    reset = 0; idle(); bus.flush = 1;
    repeat (65540) @(posedge clk);
    #2;
    chk("sat_cnt", 32'(bus.bubble_cnt), 32'h0000_FFFF);
    step();
    chk("sat_hold", 32'(bus.bubble_cnt), 32'h0000_FFFF);
    bus.flush = 0;
    step();
    chk("sat_invalid_load", 32'(bus.bubble_cnt), 32'h0000_FFFF);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
